// File: rtl/cdc_tx_pkg.sv
// -----------------------------------------------------------------------------
// cdc_tx_pkg
// Shared types and limits for the four-phase req/ack transmit block.
//   cdc_tx_state_t   : handshake FSM states
//   SYNC_STAGES_MIN  : shortest legal ack synchronizer chain
//   SYNC_STAGES_MAX  : longest legal ack synchronizer chain
// -----------------------------------------------------------------------------
package cdc_tx_pkg;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      REQ_HIGH     = 2'd1,
      WAIT_ACK_LOW = 2'd2
   } cdc_tx_state_t;

   localparam int SYNC_STAGES_MIN = 2;
   localparam int SYNC_STAGES_MAX = 4;

endpackage

// File: rtl/cdc_req_tx_ack_sync.sv
// -----------------------------------------------------------------------------
// ack_sync
// Multi-flop synchronizer bringing the remote acknowledge into the clk domain.
//   clk       in  : local clock
//   rst       in  : asynchronous active-high reset, clears every stage to 0
//   ack_async in  : remote acknowledge, asynchronous to clk
//   ack_s     out : synchronized acknowledge (last flop of the chain)
// -----------------------------------------------------------------------------
module ack_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic ack_async,
   output logic ack_s
);

   logic [SYNC_STAGES-1:0] sync_q;

   // NOTE: synchronizer flops are reset so a stale ack cannot appear as a
   // spurious edge out of reset; the chain is tiny, so resetting it is free.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], ack_async};
      end
   end

   assign ack_s = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/cdc_req_tx.sv
// -----------------------------------------------------------------------------
// cdc_req_tx
// Transmit end of a four-phase return-to-zero req/ack CDC handshake. A word
// accepted on the valid/ready side is held on data_out while req is raised,
// then the block waits for the synchronized ack to rise and fall again.
//
// Optional feature: define CDC_TX_TIMEOUT_EN to add a per-phase timeout that
// abandons a stuck handshake and pulses err. Without it err is constant 0.
//
// Ports:
//   clk       in                 : single clock, rising edge
//   rst       in                 : asynchronous active-high reset
//   tx_valid  in                 : local word available
//   tx_data   in  [DATA_WIDTH]   : local word
//   tx_ready  out                : block can accept a word this cycle
//   req       out                : registered request to the remote domain
//   data_out  out [DATA_WIDTH]   : held word, stable while a transfer runs
//   ack_async in                 : remote acknowledge, asynchronous
//   done      out                : one-cycle pulse on normal completion
//   err       out                : one-cycle pulse on timeout
// -----------------------------------------------------------------------------
module cdc_req_tx
   import cdc_tx_pkg::*;
#(
   parameter int DATA_WIDTH     = 8,
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  tx_valid,
   input  logic [DATA_WIDTH-1:0] tx_data,
   output logic                  tx_ready,
   output logic                  req,
   output logic [DATA_WIDTH-1:0] data_out,
   input  logic                  ack_async,
   output logic                  done,
   output logic                  err
);

   // Elaboration-time guard on configuration.
   if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync
      $error("cdc_req_tx: SYNC_STAGES out of range");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_bad_tmo
      $error("cdc_req_tx: TIMEOUT_CYCLES must be at least 1");
   end

   cdc_tx_state_t state;
   logic          ack_s;

   ack_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_ack_sync (
      .clk       (clk),
      .rst       (rst),
      .ack_async (ack_async),
      .ack_s     (ack_s)
   );

   // A stale remote ack (e.g. left high across our reset) must drain before a
   // new request, otherwise the remote would see req rise with ack already up.
   assign tx_ready = (state == IDLE) && !ack_s;

`ifdef CDC_TX_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TMO_W-1:0] tmo_cnt;
   logic             tmo_hit;
   logic             aborted;  // current WAIT_ACK_LOW follows a REQ_HIGH timeout

   // Fires on the edge at which the phase counter would reach the limit.
   assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
   assign err = 1'b0;
`endif

   // NOTE: all FSM state and outputs use non-blocking assignments so every
   // register samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         req      <= 1'b0;
         data_out <= '0;
         done     <= 1'b0;
`ifdef CDC_TX_TIMEOUT_EN
         err      <= 1'b0;
         tmo_cnt  <= '0;
         aborted  <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
`ifdef CDC_TX_TIMEOUT_EN
         err <= 1'b0;
         // Counts only while a handshake phase is open; transitions below
         // clear it again.
         tmo_cnt <= (state == IDLE) ? '0 : tmo_cnt + 1'b1;
`endif
         case (state)
            IDLE: begin
               if (tx_valid && tx_ready) begin
                  data_out <= tx_data;
                  req      <= 1'b1;
                  state    <= REQ_HIGH;
               end
            end

            REQ_HIGH: begin
               if (ack_s) begin
                  req   <= 1'b0;
                  state <= WAIT_ACK_LOW;
`ifdef CDC_TX_TIMEOUT_EN
                  tmo_cnt <= '0;
               end else if (tmo_hit) begin
                  req     <= 1'b0;
                  err     <= 1'b1;
                  aborted <= 1'b1;
                  state   <= WAIT_ACK_LOW;
                  tmo_cnt <= '0;
`endif
               end
            end

            WAIT_ACK_LOW: begin
               if (!ack_s) begin
                  state <= IDLE;
`ifdef CDC_TX_TIMEOUT_EN
                  // An abandoned transfer never reports completion.
                  done    <= !aborted;
                  aborted <= 1'b0;
                  tmo_cnt <= '0;
               end else if (tmo_hit) begin
                  err     <= 1'b1;
                  aborted <= 1'b0;
                  state   <= IDLE;
                  tmo_cnt <= '0;
`else
                  done  <= 1'b1;
`endif
               end
            end

            // NOTE: explicit recovery arm keeps an illegal encoding from
            // locking up the handshake.
            default: begin
               state <= IDLE;
               req   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cdc_req_tx.sv
// -----------------------------------------------------------------------------
// tb_cdc_req_tx
// Self-checking bench for cdc_req_tx (SYNC_STAGES=2, TIMEOUT_CYCLES=10).
// A remote-side responder answers req with randomized delays; accepted words
// are queued and a monitor checks each done pulse against the queue head.
// Define CDC_TX_TIMEOUT_EN for the bench and RTL together to exercise timeout.
// -----------------------------------------------------------------------------
module tb_cdc_req_tx;

   localparam int DW  = 8;
   localparam int SS  = 2;
   localparam int TMO = 10;

   logic          tb_clk = 1'b0;
   logic          rst;
   logic          tx_valid;
   logic [DW-1:0] tx_data;
   logic          tx_ready;
   logic          req;
   logic [DW-1:0] data_out;
   logic          ack_async;
   logic          done;
   logic          err;

   logic ack_remote;   // driven by the responder process
   logic ack_force;    // driven by the main sequence for stale-ack scenarios
   assign ack_async = ack_remote | ack_force;

   always #5 tb_clk = ~tb_clk;

   cdc_req_tx #(
      .DATA_WIDTH     (DW),
      .SYNC_STAGES    (SS),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk       (tb_clk),
      .rst       (rst),
      .tx_valid  (tx_valid),
      .tx_data   (tx_data),
      .tx_ready  (tx_ready),
      .req       (req),
      .data_out  (data_out),
      .ack_async (ack_async),
      .done      (done),
      .err       (err)
   );

   int            total  = 0;
   int            bad    = 0;
   int            n_sent = 0;
   int            n_done = 0;
   logic [DW-1:0] exp_q[$];
   bit            remote_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Global time bound.
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "watchdog expired");
   end

   // Monitor: every done must match the oldest outstanding word; held data
   // must not move while req stays high.
   initial begin
      logic          prev_req;
      logic [DW-1:0] held;
      logic [DW-1:0] exp;
      prev_req = 1'b0;
      held     = '0;
      forever begin
         @(negedge tb_clk);
         if (rst) begin
            prev_req = 1'b0;
         end else begin
            if (done) begin
               n_done++;
               check("done_queue_depth", exp_q.size(), 1);
               if (exp_q.size() != 0) begin
                  exp = exp_q.pop_front();
                  check("done_data", data_out, exp);
               end
               check("ready_with_done", tx_ready, 1);
            end
            if (prev_req && req) check("data_stable", data_out, held);
`ifndef CDC_TX_TIMEOUT_EN
            if (err) check("err_tied_low", err, 0);
`endif
            prev_req = req;
            held     = data_out;
         end
      end
   end

   // Remote responder: four-phase return-to-zero with random think time.
   // Latencies are counted in falling edges after ack changes: the first
   // rising edge latches ack, then SYNC_STAGES more edges reach the FSM output.
   initial begin
      int n;
      ack_remote = 1'b0;
      forever begin
         @(negedge tb_clk);
         if (remote_en && req && !ack_async && !rst) begin
            repeat ($urandom_range(0, 3)) @(negedge tb_clk);
            ack_remote = 1'b1;
            n = 0;
            do begin
               @(negedge tb_clk);
               n++;
            end while (req && n < 20);
            check("req_fall_latency", n, SS + 1);
            repeat ($urandom_range(0, 3)) @(negedge tb_clk);
            ack_remote = 1'b0;
            n = 0;
            do begin
               @(negedge tb_clk);
               n++;
            end while (!done && n < 20);
            check("done_latency", n, SS + 1);
         end
      end
   end

   // Present a word and wait (bounded) for acceptance. Called and returns on a
   // falling edge. With hold=0 tx_valid drops after acceptance.
   task automatic send(input logic [DW-1:0] w, input bit hold);
      int n;
      n        = 0;
      tx_data  = w;
      tx_valid = 1'b1;
      while (!tx_ready && n < 200) begin
         @(negedge tb_clk);
         n++;
      end
      if (!tx_ready) begin
         check("accept_timeout", tx_ready, 1);
         tx_valid = 1'b0;
         return;
      end
      check("no_overlap", exp_q.size(), 0);
      @(posedge tb_clk);
      exp_q.push_back(w);
      n_sent++;
      @(negedge tb_clk);
      check("req_after_accept", req, 1);
      check("data_after_accept", data_out, w);
      if (!hold) tx_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge tb_clk);
         n++;
      end
      check("drain", exp_q.size(), 0);
   endtask

   initial begin
      int n;
      bit hold;
      rst       = 1'b1;
      tx_valid  = 1'b1;
      tx_data   = 8'hFF;
      ack_force = 1'b0;

      // Reset state, with tx_valid asserted during reset.
      repeat (3) @(negedge tb_clk);
      check("rst_req", req, 0);
      check("rst_data_out", data_out, 0);
      check("rst_tx_ready", tx_ready, 1);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      tx_valid = 1'b0;
      rst      = 1'b0;
      @(negedge tb_clk);
      remote_en = 1'b1;

      // Single transfer.
      send(8'hA5, 1'b0);
      drain();

      // Back-to-back with tx_valid held high.
      send(8'h11, 1'b1);
      send(8'h22, 1'b0);
      drain();

      // Randomized traffic.
      for (int i = 0; i < 20; i++) begin
         hold = 1'($urandom_range(0, 1));
         send(8'($urandom), hold);
         if (!hold) repeat ($urandom_range(0, 4)) @(negedge tb_clk);
      end
      tx_valid = 1'b0;
      drain();
      @(negedge tb_clk);

      // Stale ack held through reset release.
      remote_en = 1'b0;
      ack_force = 1'b1;
      rst       = 1'b1;
      repeat (2) @(negedge tb_clk);
      rst = 1'b0;
      repeat (SS + 1) @(negedge tb_clk);
      check("stale_ack_ready", tx_ready, 0);
      tx_data  = 8'h5A;
      tx_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge tb_clk);
         check("stale_ack_no_req", req, 0);
         check("stale_ack_blocked", tx_ready, 0);
      end
      tx_valid  = 1'b0;
      ack_force = 1'b0;
      n = 0;
      while (!tx_ready && n < 20) begin
         @(negedge tb_clk);
         n++;
      end
      check("stale_ack_release", n, SS);
      remote_en = 1'b1;
      send(8'h3C, 1'b0);
      drain();
      @(negedge tb_clk);

      // Reset while in REQ_HIGH.
      remote_en = 1'b0;
      send(8'hC3, 1'b0);
      repeat (2) @(negedge tb_clk);
      check("mid_req_high", req, 1);
      rst = 1'b1;
      #1;
      check("mid_rst_req_async", req, 0);
      void'(exp_q.pop_back());
      n_sent--;
      @(negedge tb_clk);
      check("mid_rst_done", done, 0);
      rst = 1'b0;
      @(negedge tb_clk);
      remote_en = 1'b1;
      send(8'h96, 1'b0);
      drain();
      @(negedge tb_clk);

      // Remote never acks.
      remote_en = 1'b0;
      send(8'h7E, 1'b0);
`ifdef CDC_TX_TIMEOUT_EN
      n = 0;
      while (!err && n < 50) begin
         @(negedge tb_clk);
         n++;
      end
      check("err_latency", n, TMO);
      check("req_after_err", req, 0);
      void'(exp_q.pop_back());
      n_sent--;
      @(negedge tb_clk);
      check("idle_after_err", tx_ready, 1);
      check("no_done_after_err", done, 0);
      check("err_one_cycle", err, 0);
`else
      repeat (30) @(negedge tb_clk);
      check("req_stuck_high", req, 1);
      check("err_never", err, 0);
      rst = 1'b1;
      #1;
      void'(exp_q.pop_back());
      n_sent--;
      @(negedge tb_clk);
      rst = 1'b0;
      @(negedge tb_clk);
`endif
      repeat (3) @(negedge tb_clk);
      check("xfer_count", n_done, n_sent);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
